// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned JIDX_W = 26;
    localparam int unsigned JHI_W  = 4;

    localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_e;

    // Force an address onto a word boundary.
    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return addr & ~ADDR_W'(3);
    endfunction

endpackage

// File: rtl/fetch_pcmux.sv
// Next-pc selection: flush, then jump, then taken branch, then sequential.
module fetch_pcmux
    import fetch_pkg::*;
(
    input  logic              i_flush,
    input  logic [ADDR_W-1:0] i_flush_pc,
    input  logic              i_consume,
    input  logic              i_jump,
    input  logic              i_pcsrc,
    input  logic [ADDR_W-1:0] i_pcbranch,
    input  logic [ADDR_W-1:0] i_pcplus4,
    input  logic [JHI_W-1:0]  i_pc_hi,
    input  logic [JIDX_W-1:0] i_jidx,
    input  logic [ADDR_W-1:0] i_pc,
    output logic [ADDR_W-1:0] o_pc_next
);

    always_comb begin
        o_pc_next = i_pc;
        if (i_flush) begin
            o_pc_next = word_align(i_flush_pc);
        end else if (i_consume) begin
            if (i_jump) begin
                o_pc_next = {i_pc_hi, i_jidx, 2'b00};
            end else if (i_pcsrc) begin
                o_pc_next = word_align(i_pcbranch);
            end else begin
                o_pc_next = i_pcplus4;
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch: request, hold for the decoder, redirect on
// consume or flush, and drain a response that was in flight when a flush hit.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] pcplus4,
    output logic              instr_valid,
    input  logic              stall,
    input  logic              pcsrc,
    input  logic              jump,
    input  logic [ADDR_W-1:0] pcbranch,
    input  logic              flush,
    input  logic [ADDR_W-1:0] flush_pc,
    output logic [31:0]       retired
);

    fetch_state_e      r_state;
    fetch_state_e      w_next_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_addr;
    logic              r_imem_req;
    logic [DATA_W-1:0] r_instr;
    logic [ADDR_W-1:0] r_pcplus4;
    logic              r_instr_valid;
    logic [31:0]       r_retired;

    logic              w_ready;
    logic              w_consume;
    logic              w_latch;
    logic [ADDR_W-1:0] w_pc_next;
    logic [ADDR_W-1:0] w_addr_next;

    // imem_ready only counts while a request is actually presented.
    assign w_ready = r_imem_req & imem_ready;

    always_comb begin
        w_next_state = r_state;
        w_consume    = 1'b0;
        w_latch      = 1'b0;
        case (r_state)
            ST_FETCH: begin
                if (flush) begin
                    w_next_state = w_ready ? ST_FETCH : ST_DRAIN;
                end else if (w_ready) begin
                    w_next_state = ST_HOLD;
                    w_latch      = 1'b1;
                end
            end
            ST_HOLD: begin
                if (flush) begin
                    w_next_state = ST_FETCH;
                end else if (r_instr_valid && !stall) begin
                    w_consume    = 1'b1;
                    w_next_state = ST_FETCH;
                end
            end
            ST_DRAIN: begin
                if (!flush && w_ready) begin
                    w_next_state = ST_FETCH;
                end
            end
            default: w_next_state = ST_FETCH;
        endcase
    end

    fetch_pcmux u_pcmux (
        .i_flush    (flush),
        .i_flush_pc (flush_pc),
        .i_consume  (w_consume),
        .i_jump     (jump),
        .i_pcsrc    (pcsrc),
        .i_pcbranch (pcbranch),
        .i_pcplus4  (r_pcplus4),
        .i_pc_hi    (r_pcplus4[ADDR_W-1 -: JHI_W]),
        .i_jidx     (r_instr[JIDX_W-1:0]),
        .i_pc       (r_pc),
        .o_pc_next  (w_pc_next)
    );

    // DRAIN keeps presenting the abandoned address until the memory answers it.
    assign w_addr_next = (w_next_state == ST_FETCH) ? w_pc_next : r_addr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_FETCH;
            r_pc          <= RESET_PC;
            r_addr        <= RESET_PC;
            r_imem_req    <= 1'b0;
            r_instr       <= '0;
            r_pcplus4     <= '0;
            r_instr_valid <= 1'b0;
            r_retired     <= '0;
        end else begin
            r_state       <= w_next_state;
            r_pc          <= w_pc_next;
            r_addr        <= w_addr_next;
            r_imem_req    <= (w_next_state != ST_HOLD);
            r_instr_valid <= (w_next_state == ST_HOLD);
            if (w_latch) begin
                r_instr   <= imem_rdata;
                r_pcplus4 <= r_pc + ADDR_W'(4);
            end
            if (w_consume) begin
                r_retired <= r_retired + 32'd1;
            end
        end
    end

    assign imem_req    = r_imem_req;
    assign imem_addr   = r_addr;
    assign instr       = r_instr;
    assign pcplus4     = r_pcplus4;
    assign instr_valid = r_instr_valid;
    assign retired     = r_retired;

endmodule
